// File: rtl/fp_fmt_pkg.sv
// rtl/fp_fmt_pkg.sv - shared FP16 / unified FP29i format definitions
// Purpose: field widths, exponent biases, FP16 special encodings, the unified
//          word typedef and the leading-zero counter used by the packer.
// Ports:   none (package).
package fp_fmt_pkg;

  localparam int FP16_SGN_W = 1;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam int U_SGN_W = 1;
  localparam int U_EXP_W = 6;
  localparam int U_MAN_W = 22;

  localparam int FP16_EXP_BIAS = 15;
  localparam int U_EXP_BIAS    = 31;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_MAX_FIN = 16'h7BFF;

  typedef struct packed {
    logic                sgn;
    logic [U_EXP_W-1:0]  exp;
    logic [U_MAN_W-1:0]  man_dn;
  } fp29i_t;

  // Leading zeros above the first set bit of a 22-bit mantissa (0..21).
  // An all-zero word also returns 21; the caller detects zero separately.
  function automatic logic [4:0] count_lead_zero(input logic [U_MAN_W-1:0] v);
    logic [4:0] n;
    n = 5'd21;
    for (int i = 0; i < U_MAN_W; i++) begin
      if (v[i]) n = 5'(21 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp29i_to_fp16_pack_if.sv
// rtl/fp29i_to_fp16_pack_if.sv - handshake/data bundle for the FP16 packer
// Purpose: groups the input word handshake, output result handshake and the
//          sticky flag controls of fp29i_to_fp16_pack.
// Ports:   none; modport slave is the packer side, modport master the
//          producer/consumer side.
interface fp29i_to_fp16_pack_if;
  import fp_fmt_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_sgn;
  logic [U_EXP_W-1:0] in_exp;
  logic [U_MAN_W-1:0] in_man_dn;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_fp16;
  logic               flag_clr;
  logic               flag_ovf;
  logic               flag_unf;
  logic               flag_inx;

  modport slave (
    input  in_valid, in_sgn, in_exp, in_man_dn, out_ready, flag_clr,
    output in_ready, out_valid, out_fp16, flag_ovf, flag_unf, flag_inx
  );

  modport master (
    output in_valid, in_sgn, in_exp, in_man_dn, out_ready, flag_clr,
    input  in_ready, out_valid, out_fp16, flag_ovf, flag_unf, flag_inx
  );

endinterface

// File: rtl/fp16_round_rne.sv
// rtl/fp16_round_rne.sv - combinational FP16 round-to-nearest-even stage
// Purpose: turns a normalised 22-bit mantissa and rebiased exponent into an
//          IEEE FP16 word with overflow/underflow/inexact indications.
//          Macro FP16_SAT_EN: overflow saturates to the largest finite value
//          instead of producing infinity.
// Ports:   i_nm   - normalised mantissa, bit21 set unless the value is zero
//          i_e16  - signed FP16 exponent field before range handling
//          i_sgn  - sign
//          o_fp16 - packed result; o_ovf/o_unf/o_inx - exception indications
module fp16_round_rne
  import fp_fmt_pkg::*;
(
  input  logic [21:0]       i_nm,
  input  logic signed [7:0] i_e16,
  input  logic              i_sgn,
  output logic [15:0]       o_fp16,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_inx
);

`ifdef FP16_SAT_EN
  localparam logic [15:0] C_OVF_MAG = FP16_MAX_FIN;
`else
  localparam logic [15:0] C_OVF_MAG = FP16_POS_INF;
`endif

  logic signed [7:0] w_diff;
  logic [4:0]        w_sh;
  logic [44:0]       w_ext;
  logic [4:0]        w_exp_pre;
  logic [9:0]        w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic              w_inx;
  logic [14:0]       w_mag;

  always_comb begin
    w_diff    = 8'sd1 - i_e16;
    w_sh      = 5'd0;
    w_ext     = '0;
    w_exp_pre = '0;
    w_frac    = '0;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    o_fp16    = {i_sgn, 15'b0};
    o_ovf     = 1'b0;
    o_unf     = 1'b0;
    o_inx     = 1'b0;

    if (i_e16 < 8'sd1) begin
      // Subnormal: denormalise by (1 - e16). Beyond 24 places every bit
      // lands in sticky anyway, so the shift is clamped there.
      w_sh      = (w_diff > 8'sd24) ? 5'd24 : w_diff[4:0];
      w_ext     = 45'({i_nm, 24'b0} >> w_sh);
      w_frac    = w_ext[44:35];
      w_guard   = w_ext[34];
      w_sticky  = |w_ext[33:0];
    end else begin
      w_exp_pre = i_e16[4:0];
      w_frac    = i_nm[20:11];
      w_guard   = i_nm[10];
      w_sticky  = |i_nm[9:0];
    end

    w_inc = w_guard & (w_sticky | w_frac[0]);
    w_inx = w_guard | w_sticky;
    // Carry out of the fraction ripples into the exponent field, which also
    // promotes the largest subnormal to the minimum normal.
    w_mag = {w_exp_pre, w_frac} + {14'b0, w_inc};

    if (i_nm == 22'd0) begin
      o_fp16 = {i_sgn, 15'b0};
    end else if ((i_e16 > 8'sd30) || (w_mag[14:10] == 5'h1F)) begin
      o_fp16 = {i_sgn, C_OVF_MAG[14:0]};
      o_ovf  = 1'b1;
      o_inx  = 1'b1;
    end else begin
      o_fp16 = {i_sgn, w_mag};
      o_inx  = w_inx;
      o_unf  = w_inx & (w_exp_pre == 5'd0);
    end
  end

endmodule

// File: rtl/fp29i_to_fp16_pack.sv
// rtl/fp29i_to_fp16_pack.sv - 2-stage FP29i to IEEE FP16 output packer
// Purpose: normalises the unified FPALU result, rebiases, rounds RNE and
//          packs to FP16 with valid/ready backpressure and sticky flags.
//          Macro FP16_SAT_EN (in fp16_round_rne) selects saturating overflow.
// Ports:   clk  - clock, all state on posedge
//          rst  - asynchronous active-high reset
//          s_if - slave side of fp29i_to_fp16_pack_if (input word, output
//                 result handshake, flag_clr and sticky ovf/unf/inx flags)
module fp29i_to_fp16_pack #(
  parameter int LAT_STAGES   = 2,
  parameter int IN_EXP_BIAS  = 31,
  parameter int OUT_EXP_BIAS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  fp29i_to_fp16_pack_if.slave  s_if
);
  import fp_fmt_pkg::*;

  if (LAT_STAGES != 2) begin : g_bad_lat
    $error("fp29i_to_fp16_pack: LAT_STAGES must be 2");
  end

  localparam logic [7:0] C_REBIAS = 8'(IN_EXP_BIAS - OUT_EXP_BIAS);

  fp29i_t            w_in;
  logic [4:0]        w_lz;
  logic [21:0]       w_nm;
  logic signed [7:0] w_e16;
  logic              w_en;
  logic              w_xfer2;
  logic [15:0]       w_fp16;
  logic              w_ovf;
  logic              w_unf;
  logic              w_inx;

  logic              r_s1_valid;
  logic              r_s1_sgn;
  logic [21:0]       r_s1_nm;
  logic signed [7:0] r_s1_e16;
  logic              r_out_valid;
  logic [15:0]       r_out_fp16;
  logic              r_flag_ovf;
  logic              r_flag_unf;
  logic              r_flag_inx;

  // A single enable stalls the whole pipe whenever the output is full and
  // not being taken; otherwise every stage advances, bubbles included.
  assign w_en    = ~r_out_valid | s_if.out_ready;
  assign w_xfer2 = w_en & r_s1_valid;

  assign w_in  = {s_if.in_sgn, s_if.in_exp, s_if.in_man_dn};
  assign w_lz  = count_lead_zero(w_in.man_dn);
  assign w_nm  = w_in.man_dn << w_lz;
  assign w_e16 = {2'b00, w_in.exp} - C_REBIAS - {3'b000, w_lz};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_nm    <= '0;
      r_s1_e16   <= '0;
    end else if (w_en) begin
      r_s1_valid <= s_if.in_valid;
      if (s_if.in_valid) begin
        r_s1_sgn <= w_in.sgn;
        r_s1_nm  <= w_nm;
        r_s1_e16 <= w_e16;
      end
    end
  end

  fp16_round_rne u_round (
    .i_nm   (r_s1_nm),
    .i_e16  (r_s1_e16),
    .i_sgn  (r_s1_sgn),
    .o_fp16 (w_fp16),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf),
    .o_inx  (w_inx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_fp16  <= 16'h0000;
      r_flag_ovf  <= 1'b0;
      r_flag_unf  <= 1'b0;
      r_flag_inx  <= 1'b0;
    end else begin
      if (w_en) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_fp16 <= w_fp16;
      end
      // Clear first, then OR in the new event so a coincident event wins.
      r_flag_ovf <= (r_flag_ovf & ~s_if.flag_clr) | (w_xfer2 & w_ovf);
      r_flag_unf <= (r_flag_unf & ~s_if.flag_clr) | (w_xfer2 & w_unf);
      r_flag_inx <= (r_flag_inx & ~s_if.flag_clr) | (w_xfer2 & w_inx);
    end
  end

  assign s_if.in_ready  = w_en;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_fp16  = r_out_fp16;
  assign s_if.flag_ovf  = r_flag_ovf;
  assign s_if.flag_unf  = r_flag_unf;
  assign s_if.flag_inx  = r_flag_inx;

endmodule

// File: tb/tb_fp29i_to_fp16_pack.sv
// tb/tb_fp29i_to_fp16_pack.sv - self-checking bench for fp29i_to_fp16_pack
module tb_fp29i_to_fp16_pack;

`ifdef FP16_SAT_EN
  localparam logic [15:0] OVF_MAG = 16'h7BFF;
`else
  localparam logic [15:0] OVF_MAG = 16'h7C00;
`endif

  typedef struct {
    logic        sgn;
    logic [5:0]  exp;
    logic [21:0] man;
    logic [15:0] fp16;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  logic clk;
  logic rst;
  fp29i_to_fp16_pack_if bus();

  fp29i_to_fp16_pack #(
    .LAT_STAGES   (2),
    .IN_EXP_BIAS  (31),
    .OUT_EXP_BIAS (15)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] mon_exp;
  logic [15:0] held;
  vec_t        vecs[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every result handed over is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got 0x%0h expected no word", bus.out_fp16);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_fp16", {16'h0, bus.out_fp16}, {16'h0, mon_exp});
      end
    end
  end

  task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m, input logic [15:0] exp16);
    bit ok;
    ok = 0;
    bus.in_valid  = 1'b1;
    bus.in_sgn    = s;
    bus.in_exp    = e;
    bus.in_man_dn = m;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) sb_q.push_back(exp16);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    #1;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic clear_flags();
    bus.flag_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.flag_clr = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 6'd31, 22'h200000, 16'h3C00,          1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 6'd33, 22'h080000, 16'h3C00,          1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 6'd40, 22'h000000, 16'h8000,          1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 6'd31, 22'h200400, 16'h3C00,          1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 6'd31, 22'h200C00, 16'h3C02,          1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 6'd46, 22'h3FFC00, OVF_MAG,           1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 6'd46, 22'h3FF800, 16'h7BFF,          1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 6'd7,  22'h200000, 16'h0001,          1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 6'd6,  22'h200000, 16'h0000,          1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 6'd63, 22'h000001, 16'hE800,          1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 6'd16, 22'h3FFFFF, 16'h0400,          1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 6'd0,  22'h000001, 16'h8000,          1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 6'd17, 22'h200000, 16'h0400,          1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 6'd63, 22'h200000, 16'h8000 | OVF_MAG, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 6'd15, 22'h200000, 16'h0100,          1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_sgn    = 1'b0;
    bus.in_exp    = '0;
    bus.in_man_dn = '0;
    bus.out_ready = 1'b1;
    bus.flag_clr  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_fp16", {16'h0, bus.out_fp16}, 32'h0);
    check("rst_flags", {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: accepted on one edge, result registered on the next.
    send(1'b0, 6'd31, 22'h200000, 16'h3C00);
    check("lat_early", {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'h0, bus.out_valid}, 32'h1);
    check("lat_data", {16'h0, bus.out_fp16}, 32'h3C00);
    drain();
    check("lat_flags", {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      clear_flags();
      send(vecs[i].sgn, vecs[i].exp, vecs[i].man, vecs[i].fp16);
      drain();
      check($sformatf("flags_v%0d", i), {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx},
            {29'h0, vecs[i].ovf, vecs[i].unf, vecs[i].inx});
    end

    // flag_clr on the same edge as an inexact result: old ovf clears, inx stays.
    clear_flags();
    send(vecs[5].sgn, vecs[5].exp, vecs[5].man, vecs[5].fp16);
    drain();
    check("ovf_set", {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'h5);
    send(vecs[3].sgn, vecs[3].exp, vecs[3].man, vecs[3].fp16);
    bus.flag_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.flag_clr = 1'b0;
    check("clr_vs_event", {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'h1);
    drain();
    clear_flags();
    check("clr_clears", {29'h0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'h0);

    // Backpressure: consumer stalls while four words are in flight.
    fork
      begin
        send(vecs[0].sgn, vecs[0].exp, vecs[0].man, vecs[0].fp16);
        send(vecs[4].sgn, vecs[4].exp, vecs[4].man, vecs[4].fp16);
        send(vecs[7].sgn, vecs[7].exp, vecs[7].man, vecs[7].fp16);
        send(vecs[9].sgn, vecs[9].exp, vecs[9].man, vecs[9].fp16);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        held = bus.out_fp16;
        check("bp_held_word", {16'h0, held}, {16'h0, vecs[4].fp16});
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
          check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
          check("bp_hold", {16'h0, bus.out_fp16}, {16'h0, held});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a word sitting in the output register.
    send(vecs[12].sgn, vecs[12].exp, vecs[12].man, vecs[12].fp16);
    @(posedge clk);
    #2;
    check("rst_pre_valid", {31'h0, bus.out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_async_fp16", {16'h0, bus.out_fp16}, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(vecs[1].sgn, vecs[1].exp, vecs[1].man, vecs[1].fp16);
    drain();
    check("sb_leftover", sb_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
